// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory while holding the core in reset.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.

module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int BPW = WIDTH / 8,
    localparam int AW  = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [AW:0]      len_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             we_o,
    output logic [AW-1:0]    wa_o,
    output logic [WIDTH-1:0] wd_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             core_rst_n_o
);

    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [AW:0]      DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [BIW-1:0]   IDX_ZERO  = {BIW{1'b0}};
    localparam logic [BIW-1:0]   IDX_ONE   = BIW'(1);
    localparam logic [BIW-1:0]   IDX_LAST  = BIW'(BPW - 1);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_FIN   = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [AW:0]      len_r, cnt_r, cnt_inc_s;
    logic [BIW-1:0]   idx_r;
    logic [WIDTH-1:0] word_r, word_asm_s;
    logic             accept_s, start_ok_s, start_bad_s;
    logic             err_r, we_r, busy_r, done_r, ready_r, core_rst_r;
    logic [AW-1:0]    wa_r;
    logic [WIDTH-1:0] wd_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_r;
    logic             chk_accept_s;
`endif

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Word being assembled, with the incoming byte dropped into its little-endian lane.
    always_comb begin
        word_asm_s = word_r;
        word_asm_s[{idx_r, 3'b000} +: 8] = byte_i;
    end

    // Next-state decode and handshake qualifiers.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_accept_s = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    if ((len_i == CNT_ZERO) || (len_i > DEPTH_L)) begin
                        start_bad_s = 1'b1;
                        state_s     = S_FIN;
                    end else begin
                        start_ok_s  = 1'b1;
                        state_s     = S_RECV;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RECV: begin
                if (byte_valid_i && ready_r) begin
                    accept_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        state_s = S_WRITE;
                    end else begin
                        state_s = S_RECV;
                    end
                end else begin
                    state_s = S_RECV;
                end
            end
            S_WRITE: begin
                if (cnt_inc_s == len_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_s = S_CHECK;
`else
                    state_s = S_FIN;
`endif
                end else begin
                    state_s = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (byte_valid_i && ready_r) begin
                    chk_accept_s = 1'b1;
                    state_s      = S_FIN;
                end else begin
                    state_s = S_CHECK;
                end
            end
`endif
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Session length, word counter, byte index and assembly buffer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_r  <= CNT_ZERO;
            cnt_r  <= CNT_ZERO;
            idx_r  <= IDX_ZERO;
            word_r <= WORD_ZERO;
        end else if (start_ok_s) begin
            len_r  <= len_i;
            cnt_r  <= CNT_ZERO;
            idx_r  <= IDX_ZERO;
            word_r <= WORD_ZERO;
        end else begin
            if (accept_s) begin
                word_r <= word_asm_s;
                idx_r  <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_ONE;
            end
            if (state_r == S_WRITE) begin
                cnt_r <= cnt_inc_s;
            end
        end
    end

    // Sticky error flag, cleared only by a well-formed start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_r <= 1'b0;
        end else if (start_ok_s) begin
            err_r <= 1'b0;
        end else if (start_bad_s) begin
            err_r <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        end else if (chk_accept_s && (byte_i != csum_r)) begin
            err_r <= 1'b1;
`endif
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted program byte.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csum_r <= 8'h00;
        end else if (start_ok_s) begin
            csum_r <= 8'h00;
        end else if (accept_s) begin
            csum_r <= csum_r ^ byte_i;
        end
    end
`endif

    // Registered outputs, all derived from the upcoming state so they align with it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_r       <= 1'b0;
            wa_r       <= {AW{1'b0}};
            wd_r       <= WORD_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b0;
            core_rst_r <= 1'b0;
        end else begin
            we_r <= (state_s == S_WRITE);
            if (state_s == S_WRITE) begin
                wa_r <= cnt_r[AW-1:0];
                wd_r <= word_asm_s;
            end
            busy_r     <= (state_s != S_IDLE);
            done_r     <= (state_s == S_FIN);
`ifdef IMEM_LOADER_CHECKSUM_EN
            ready_r    <= (state_s == S_RECV) || (state_s == S_CHECK);
`else
            ready_r    <= (state_s == S_RECV);
`endif
            core_rst_r <= (state_s == S_IDLE);
        end
    end

    assign byte_ready_o = ready_r;
    assign we_o         = we_r;
    assign wa_o         = wa_r;
    assign wd_o         = wd_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign core_rst_n_o = core_rst_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions with a write scoreboard.
// Define IMEM_LOADER_CHECKSUM_EN to also exercise the trailing checksum byte.

module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             start      = 1'b0;
    logic [AW:0]      len        = 7'd0;
    logic [7:0]       byte_data  = 8'h00;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic             err;
    logic             core_rst_n;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int busy_cyc = 0;

    logic [AW+WIDTH-1:0] exp_q[$];
    logic [AW+WIDTH-1:0] exp_word;
    logic [7:0]          tb_xor = 8'h00;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .len_i        (len),
        .byte_i       (byte_data),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .wa_o         (wa),
        .wd_o         (wd),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .core_rst_n_o (core_rst_n)
    );

    always #5 clk = ~clk;

    // Scoreboard and activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got wa=%0d wd=%h, required no write", wa, wd);
                end else begin
                    exp_word = exp_q.pop_front();
                    if ({wa, wd} !== exp_word) begin
                        errors++;
                        $display("FAIL write_data: got wa=%0d wd=%h, required wa=%0d wd=%h",
                                 wa, wd, exp_word[AW+WIDTH-1:WIDTH], exp_word[WIDTH-1:0]);
                    end
                end
            end
            if (done) done_cnt++;
            if (busy) begin
                busy_cyc++;
                checks++;
                if (core_rst_n !== 1'b0) begin
                    errors++;
                    $display("FAIL core_rst_busy: got core_rst_n=%b, required 0 while busy", core_rst_n);
                end
            end
        end
    end

    task automatic start_session(input logic [AW:0] n);
        start  = 1'b1;
        len    = n;
        tb_xor = 8'h00;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        rdy        = 1'b0;
        n          = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk); #1;
            n++;
        end
        byte_valid = 1'b0;
        tb_xor     = tb_xor ^ b;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL byte_accept: byte %h not accepted after %0d cycles, required acceptance", b, n);
        end
    endtask

    task automatic finish_prog();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, we, busy, done, err, core_rst_n} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_flags: got ready/we/busy/done/err/core_rst_n=%b, required 000000",
                     {byte_ready, we, busy, done, err, core_rst_n});
        end
        checks++;
        if (wa !== 6'd0) begin
            errors++;
            $display("FAIL reset_wa: got %0d, required 0", wa);
        end
        checks++;
        if (wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_wd: got %h, required 0", wd);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_core: got %b, required 1", core_rst_n);
        end
    endtask

    task automatic test_basic();
        logic [7:0] prog [8];
        int d0;
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        d0   = done_cnt;
        exp_q.push_back({6'd0, 32'h00000013});
        exp_q.push_back({6'd1, 32'h00100093});
        start_session(7'd2);
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        finish_prog();
        wait_done(d0);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: got %b, required 0", err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_writes: %0d writes missing, required 0", exp_q.size());
        end
        checks++;
        if ({busy, core_rst_n} !== 2'b01) begin
            errors++;
            $display("FAIL basic_idle: got busy/core_rst_n=%b, required 01", {busy, core_rst_n});
        end
    endtask

    task automatic test_len_bad();
        int d0, b0;
        d0 = done_cnt;
        b0 = busy_cyc;
        byte_valid = 1'b1;
        start_session(7'd0);
        wait_done(d0);
        byte_valid = 1'b0;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL len0_done: got %0d pulses, required 1", done_cnt - d0);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL len0_err: got %b, required 1", err);
        end
        checks++;
        if (busy_cyc - b0 != 1) begin
            errors++;
            $display("FAIL len0_busy: got %0d busy cycles, required 1", busy_cyc - b0);
        end
        d0 = done_cnt;
        start_session(7'd65);
        wait_done(d0);
        checks++;
        if ({err, 1'b0} !== {1'b1, 1'b0} || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL len65: got err=%b pulses=%0d, required err=1 pulses=1", err, done_cnt - d0);
        end
    endtask

    task automatic test_toggle();
        logic [7:0] prog [8];
        int d0;
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        d0   = done_cnt;
        exp_q.push_back({6'd0, 32'h00000013});
        exp_q.push_back({6'd1, 32'h00100093});
        start_session(7'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i]);
            start = 1'b1;
            len   = 7'd0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        finish_prog();
        wait_done(d0);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL toggle_done: got %0d pulses, required 1", done_cnt - d0);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL toggle_err: got %b, required 0", err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_writes: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_full_depth();
        int d0, b0, want;
        logic [7:0] w;
        d0 = done_cnt;
        b0 = busy_cyc;
        for (int i = 0; i < DEPTH; i++) begin
            w = 8'(i);
            exp_q.push_back({w[AW-1:0], {4{w}}});
        end
        start_session(7'd64);
        for (int i = 0; i < DEPTH; i++) begin
            w = 8'(i);
            for (int k = 0; k < 4; k++) send_byte(w);
        end
        finish_prog();
        wait_done(d0);
        want = DEPTH * 5 + 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        want = want + 1;
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL depth_writes: %0d writes missing, required 0", exp_q.size());
        end
        checks++;
        if (done_cnt - d0 != 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL depth_end: got pulses=%0d err=%b, required 1 and 0", done_cnt - d0, err);
        end
        checks++;
        if (busy_cyc - b0 != want) begin
            errors++;
            $display("FAIL depth_throughput: got %0d busy cycles, required %0d", busy_cyc - b0, want);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        exp_q.push_back({6'd0, 32'h04030201});
        start_session(7'd2);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, we, busy, done, err, core_rst_n} !== 6'b000000 || wa !== 6'd0 || wd !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got flags=%b wa=%0d wd=%h, required all zero",
                     {byte_ready, we, busy, done, err, core_rst_n}, wa, wd);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_word0: %0d writes missing, required 0", exp_q.size());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        d0 = done_cnt;
        exp_q.push_back({6'd0, 32'h44332211});
        start_session(7'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        finish_prog();
        wait_done(d0);
        checks++;
        if (exp_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL midreset_restart: got missing=%0d pulses=%0d, required 0 and 1",
                     exp_q.size(), done_cnt - d0);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int d0;
        for (int pass = 0; pass < 2; pass++) begin
            d0 = done_cnt;
            exp_q.push_back({6'd0, 32'hDDCCBBAA});
            start_session(7'd1);
            send_byte(8'hAA);
            send_byte(8'hBB);
            send_byte(8'hCC);
            send_byte(8'hDD);
            send_byte((pass == 0) ? 8'h00 : 8'h01);
            wait_done(d0);
            checks++;
            if (err !== ((pass == 0) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL checksum_err: pass %0d got %b, required %b", pass, err, (pass != 0));
            end
            checks++;
            if (exp_q.size() != 0 || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL checksum_write: pass %0d missing=%0d pulses=%0d, required 0 and 1",
                         pass, exp_q.size(), done_cnt - d0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len_bad();
        test_toggle();
        test_full_depth();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits; SHALL be a multiple of 8, with BPW = WIDTH/8 bytes per word.
REQ-002 Parameter DEPTH, default 64, instruction memory depth in words; AW = $clog2(DEPTH).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, using the following ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
REQ-004 The remaining ports SHALL be:
- start_i  in  1  begin load session; sampled in IDLE only.
- len_i  in  AW+1  number of words to load; latched on start.
- byte_i  in  8  incoming program byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader accepts byte this cycle.
- we_o  out  1  instruction-memory write strobe.
- wa_o  out  AW  write word address.
- wd_o  out  WIDTH  write word data.
- busy_o  out  1  session in progress.
- done_o  out  1  one-cycle pulse at session end.
- err_o  out  1  sticky error flag.
- core_rst_n_o  out  1  active-low reset to the core, held low while busy.

Function
REQ-005 The FSM SHALL have states IDLE, RECV, WRITE, CHECK and FIN.
REQ-006 In IDLE with start_i=1:
- len_i in 1..DEPTH: latch len_i, clear the word counter, byte index and err_o, and go to RECV next cycle.
- len_i=0 or len_i>DEPTH: set err_o and go to FIN.
REQ-007 In RECV, byte_ready_o SHALL be 1; a byte is accepted only when byte_valid_i and byte_ready_o are both 1.
REQ-008 Bytes SHALL be assembled little-endian: byte k of a word goes to bits [8k+7:8k].
REQ-009 When byte BPW-1 is accepted, the FSM SHALL go to WRITE.
REQ-010 WRITE SHALL last exactly one cycle:
- we_o=1, wa_o=word counter, wd_o=assembled word, byte_ready_o=0.
- The word counter then increments.
- Next state is RECV if words remain, else CHECK (macro defined) or FIN.
REQ-011 The word counter SHALL never wrap: the last write address is len-1, and no write occurs at or beyond len.
REQ-012 we_o, wa_o and wd_o SHALL be registered; outside WRITE, we_o=0 and wa_o/wd_o hold their last values.
REQ-013 busy_o SHALL be 1 in every state except IDLE.
REQ-014 core_rst_n_o SHALL be 0 while busy_o=1, and 1 otherwise.
REQ-015 FIN SHALL last one cycle with done_o=1, then return to IDLE.
REQ-016 start_i asserted while busy_o=1 SHALL be ignored.
REQ-017 byte_valid_i outside RECV (or CHECK, when the macro is defined) SHALL be ignored; no byte is consumed.
REQ-018 Minimum throughput SHALL be one word per BPW+1 cycles.

Reset
REQ-019 While rst_n_i=0 the block SHALL hold:
- state=IDLE;
- byte_ready_o=0, we_o=0, wa_o=0, wd_o=0;
- busy_o=0, done_o=0, err_o=0;
- core_rst_n_o=0.
REQ-020 On the first clock edge after rst_n_i deasserts, core_rst_n_o SHALL go to 1.
REQ-021 Reset asserted mid-session SHALL abort immediately with no further write, and a partial word SHALL be discarded.

Configuration
REQ-022 Macro IMEM_LOADER_CHECKSUM_EN SHALL enable a trailing checksum byte:
- A running XOR of all accepted program bytes is kept.
- In CHECK, byte_ready_o=1; one byte is accepted.
- If that byte differs from the running XOR, err_o is set; then go to FIN.
REQ-023 Without IMEM_LOADER_CHECKSUM_EN:
- The CHECK state and the XOR register SHALL NOT exist.
- WRITE of the last word SHALL go directly to FIN.
- err_o SHALL be set only by REQ-006.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Length 2, bytes 13 00 00 00 93 00 10 00 -> writes wa=0 wd=32'h00000013, then wa=1 wd=32'h00100093; done_o pulses once; err_o=0.
- Length 2 with byte_valid_i toggling every other cycle -> same two writes, no lost or duplicated bytes.
- len_i=0 -> no we_o, err_o=1, done_o pulses, busy_o=1 for exactly one cycle.
- len_i=DEPTH(64), bytes = word index repeated -> 64 writes, wa 0..63, last wd=32'h3F3F3F3F, no wa wrap.
- rst_n_i low after 5 bytes of a 2-word load -> only word 0 written; all outputs at reset values; next session restarts at wa=0.
- Checksum (IMEM_LOADER_CHECKSUM_EN): 1 word AA BB CC DD + checksum 00 -> err_o=0; with checksum 01 -> err_o=1, write still occurred.
